// File: rtl/register32_8.sv
// Bank of eight WIDTH-bit registers sharing one write-data bus, with a per-register write enable.
// Optional macro REGISTER32_8_ZERO_REG_EN hardwires register 0 to zero (en[0] ignored).
module register32_8 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       en,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out0,
  output logic [WIDTH-1:0] d_out1,
  output logic [WIDTH-1:0] d_out2,
  output logic [WIDTH-1:0] d_out3,
  output logic [WIDTH-1:0] d_out4,
  output logic [WIDTH-1:0] d_out5,
  output logic [WIDTH-1:0] d_out6,
  output logic [WIDTH-1:0] d_out7
);

`ifdef REGISTER32_8_ZERO_REG_EN
  // Register 0 is cleared by reset and can never be written afterwards, so it stays zero.
  localparam logic [7:0] WR_MASK = 8'hFE;
`else
  localparam logic [7:0] WR_MASK = 8'hFF;
`endif

  logic [WIDTH-1:0] regs [8];
  logic [7:0]       wr_en;

  assign wr_en = en & WR_MASK;

  // Reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) regs[i] <= d_in;
      end
    end
  end

  assign d_out0 = regs[0];
  assign d_out1 = regs[1];
  assign d_out2 = regs[2];
  assign d_out3 = regs[3];
  assign d_out4 = regs[4];
  assign d_out5 = regs[5];
  assign d_out6 = regs[6];
  assign d_out7 = regs[7];

endmodule

// File: tb/tb_register32_8.sv
// Directed table-driven bench for register32_8, plus hand sequences for between-edge input changes.
module tb_register32_8;

  localparam logic [31:0] Z = 32'h0;
  localparam logic [31:0] O = 32'h01010101;
  localparam logic [31:0] B = 32'hDEADBEEF;
  localparam logic [31:0] A = 32'hA5A5A5A5;
  localparam logic [31:0] S = 32'h11111111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  en;
  logic [31:0] d_in;
  logic [31:0] d_out0, d_out1, d_out2, d_out3, d_out4, d_out5, d_out6, d_out7;
  logic [7:0][31:0] dout;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  register32_8 #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .d_in(d_in),
    .d_out0(d_out0), .d_out1(d_out1), .d_out2(d_out2), .d_out3(d_out3),
    .d_out4(d_out4), .d_out5(d_out5), .d_out6(d_out6), .d_out7(d_out7)
  );

  assign dout = {d_out7, d_out6, d_out5, d_out4, d_out3, d_out2, d_out1, d_out0};

  typedef struct {
    string            name;
    logic             rst_n;
    logic [7:0]       en;
    logic [31:0]      d;
    logic [7:0][31:0] exp;   // exp[i] = expected d_out i after the edge
  } vec_t;

  vec_t vecs [16];

  task automatic check_all(input string name, input logic [7:0][31:0] exp_in);
    logic [7:0][31:0] exp;
    exp = exp_in;
`ifdef REGISTER32_8_ZERO_REG_EN
    exp[0] = '0;
`endif
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (dout[i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL %s d_out%0d: got %h expected %h", name, i, dout[i], exp[i]);
      end
    end
  endtask

  initial begin
    // exp packed as {R7, R6, R5, R4, R3, R2, R1, R0}
    vecs[0]  = '{"reset",      1'b0, 8'h00, O,            {Z, Z, Z, Z, Z, Z, Z, Z}};
    vecs[1]  = '{"single_r0",  1'b1, 8'o1,  O,            {Z, Z, Z, Z, Z, Z, Z, O}};
    vecs[2]  = '{"sweep_2",    1'b1, 8'o2,  O,            {Z, Z, Z, Z, Z, Z, O, O}};
    vecs[3]  = '{"sweep_3",    1'b1, 8'o3,  O,            {Z, Z, Z, Z, Z, Z, O, O}};
    vecs[4]  = '{"sweep_4",    1'b1, 8'o4,  O,            {Z, Z, Z, Z, Z, O, O, O}};
    vecs[5]  = '{"sweep_5",    1'b1, 8'o5,  O,            {Z, Z, Z, Z, Z, O, O, O}};
    vecs[6]  = '{"sweep_6",    1'b1, 8'o6,  O,            {Z, Z, Z, Z, Z, O, O, O}};
    vecs[7]  = '{"sweep_7",    1'b1, 8'o7,  O,            {Z, Z, Z, Z, Z, O, O, O}};
    vecs[8]  = '{"write_r5",   1'b1, 8'h20, B,            {Z, Z, B, Z, Z, O, O, O}};
    vecs[9]  = '{"hold_1",     1'b1, 8'h00, 32'h12345678, {Z, Z, B, Z, Z, O, O, O}};
    vecs[10] = '{"hold_2",     1'b1, 8'h00, 32'h12345678, {Z, Z, B, Z, Z, O, O, O}};
    vecs[11] = '{"hold_3",     1'b1, 8'h00, 32'h12345678, {Z, Z, B, Z, Z, O, O, O}};
    vecs[12] = '{"rst_prio",   1'b0, 8'hFF, 32'hFFFFFFFF, {Z, Z, Z, Z, Z, Z, Z, Z}};
    vecs[13] = '{"broadcast",  1'b1, 8'hFF, A,            {A, A, A, A, A, A, A, A}};
    vecs[14] = '{"mid_reset",  1'b0, 8'h00, S,            {Z, Z, Z, Z, Z, Z, Z, Z}};
    vecs[15] = '{"resume_r7",  1'b1, 8'h80, S,            {S, Z, Z, Z, Z, Z, Z, Z}};

    reset_n = 1'b0;
    en      = 8'h00;
    d_in    = '0;

    foreach (vecs[k]) begin
      @(negedge clk);
      reset_n = vecs[k].rst_n;
      en      = vecs[k].en;
      d_in    = vecs[k].d;
      @(posedge clk);
      #1;
      check_all(vecs[k].name, vecs[k].exp);
    end

    // Between-edge changes on en/d_in must not reach the outputs; state is {S at R7} here.
    @(negedge clk);
    en   = 8'hFF;
    d_in = 32'hCAFEF00D;
    #2;
    check_all("no_comb_path", {S, Z, Z, Z, Z, Z, Z, Z});
    en   = 8'h00;
    d_in = 32'h0BADC0DE;
    @(posedge clk);
    #1;
    check_all("glitch_ignored", {S, Z, Z, Z, Z, Z, Z, Z});

    // Reset pulsed between edges only: no effect until an edge samples it low.
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    en      = 8'h08;
    d_in    = 32'h33333333;
    @(posedge clk);
    #1;
    check_all("rst_between_edges", {S, Z, Z, Z, 32'h33333333, Z, Z, Z});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
